// File: rtl/digital_clk.sv
// 24-hour time-of-day counter (seconds/minutes/hours) advanced by a prescaled second tick.
// Define DIGITAL_CLK_12H_EN to run hours in 12-hour format (12,1..11).
module digital_clk #(
  parameter int unsigned TICKS_PER_SEC = 1,
  parameter int unsigned HOURS_PER_DAY = 24
) (
  input  logic       clk,
  input  logic       rst,
  output logic [5:0] seconds,
  output logic [5:0] minutes,
  output logic [4:0] hours
);

  localparam int unsigned PW =
    (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

`ifdef DIGITAL_CLK_12H_EN
  localparam logic [4:0] HR_RST = 5'd12;
`else
  localparam logic [4:0] HR_RST = 5'd0;
  localparam logic [4:0] HR_MAX = 5'(HOURS_PER_DAY - 1);
`endif

  logic       w_sec_tick;
  logic       w_sec_wrap;
  logic       w_min_wrap;
  logic [5:0] w_sec_nxt;
  logic [5:0] w_min_nxt;
  logic [4:0] w_hr_nxt;

  logic [5:0] r_sec;
  logic [5:0] r_min;
  logic [4:0] r_hr;

  generate
    if (TICKS_PER_SEC == 1) begin : g_nopre
      assign w_sec_tick = 1'b1;
    end else begin : g_pre
      localparam logic [PW-1:0] PRE_MAX = PW'(TICKS_PER_SEC - 1);
      logic [PW-1:0] r_pre;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_pre <= '0;
        end else if (r_pre >= PRE_MAX) begin
          r_pre <= '0;
        end else begin
          r_pre <= r_pre + 1'b1;
        end
      end

      assign w_sec_tick = (r_pre >= PRE_MAX);
    end
  endgenerate

  // ">=" rather than "==" so any corrupted field recovers with a carry
  always_comb begin
    w_sec_wrap = (r_sec >= 6'd59);
    w_min_wrap = (r_min >= 6'd59);
    w_sec_nxt  = w_sec_wrap ? 6'd0 : r_sec + 6'd1;
    w_min_nxt  = w_min_wrap ? 6'd0 : r_min + 6'd1;
`ifdef DIGITAL_CLK_12H_EN
    if (r_hr == 5'd11) begin
      w_hr_nxt = 5'd12;
    end else if (r_hr >= 5'd12) begin
      w_hr_nxt = 5'd1;
    end else begin
      w_hr_nxt = r_hr + 5'd1;
    end
`else
    w_hr_nxt = (r_hr >= HR_MAX) ? 5'd0 : r_hr + 5'd1;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sec <= 6'd0;
      r_min <= 6'd0;
      r_hr  <= HR_RST;
    end else if (w_sec_tick) begin
      r_sec <= w_sec_nxt;
      if (w_sec_wrap) begin
        r_min <= w_min_nxt;
        if (w_min_wrap) begin
          r_hr <= w_hr_nxt;
        end
      end
    end
  end

  assign seconds = r_sec;
  assign minutes = r_min;
  assign hours   = r_hr;

endmodule

// File: tb/tb_digital_clk.sv
// Directed bench for digital_clk: default instance plus a TICKS_PER_SEC=4 instance.
// Hour expectations follow DIGITAL_CLK_12H_EN when it is defined.
`timescale 1ns/1ps
module tb_digital_clk;

  logic       clk;
  logic       rst;
  logic       rst4;
  logic [5:0] sec_a;
  logic [5:0] min_a;
  logic [4:0] hr_a;
  logic [5:0] sec_b;
  logic [5:0] min_b;
  logic [4:0] hr_b;

  int compared;
  int mismatched;
  int e;

  digital_clk dut (
    .clk     (clk),
    .rst     (rst),
    .seconds (sec_a),
    .minutes (min_a),
    .hours   (hr_a)
  );

  digital_clk #(.TICKS_PER_SEC(4)) dut4 (
    .clk     (clk),
    .rst     (rst4),
    .seconds (sec_b),
    .minutes (min_b),
    .hours   (hr_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int hx(input int h24);
`ifdef DIGITAL_CLK_12H_EN
    return (h24 % 12 == 0) ? 12 : h24 % 12;
`else
    return h24;
`endif
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input int h, input int m, input int s);
    chk({tag, ".s"}, int'(sec_a), s);
    chk({tag, ".m"}, int'(min_a), m);
    chk({tag, ".h"}, int'(hr_a), hx(h));
  endtask

  task automatic adv_to(input int target);
    while (e < target) begin
      @(posedge clk);
      e++;
    end
    #1;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    e          = 0;
    rst        = 1'b1;
    rst4       = 1'b1;
    @(posedge clk);
    #1;
    chk_a("reset", 0, 0, 0);
    chk("reset4.s", int'(sec_b), 0);
    chk("reset4.h", int'(hr_b), hx(0));

    // async reset between edges
    rst  = 1'b0;
    rst4 = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_a("async_rst", 0, 0, 0);
    rst4 = 1'b1;
    @(posedge clk);
    #1;
    chk_a("held_rst", 0, 0, 0);

    rst  = 1'b0;
    rst4 = 1'b0;
    e    = 0;
    adv_to(1);
    chk("first_edge.s", int'(sec_a), 1);
    chk("pre4_e1.s", int'(sec_b), 0);
    adv_to(3);
    chk("pre4_e3.s", int'(sec_b), 0);
    adv_to(4);
    chk("pre4_e4.s", int'(sec_b), 1);
    adv_to(7);
    chk("pre4_e7.s", int'(sec_b), 1);
    adv_to(8);
    chk("pre4_e8.s", int'(sec_b), 2);
    adv_to(59);
    chk_a("e59", 0, 0, 59);
    adv_to(60);
    chk_a("e60", 0, 1, 0);
    adv_to(239);
    chk("pre4_e239.s", int'(sec_b), 59);
    adv_to(240);
    chk("pre4_e240.s", int'(sec_b), 0);
    chk("pre4_e240.m", int'(min_b), 1);
    chk("pre4_e240.h", int'(hr_b), hx(0));
    adv_to(3599);
    chk_a("e3599", 0, 59, 59);
    adv_to(3600);
    chk_a("e3600", 1, 0, 0);
    adv_to(5000);
    chk_a("e5000", 1, 23, 20);
    adv_to(43199);
    chk_a("e43199", 11, 59, 59);
    adv_to(43200);
    chk_a("e43200", 12, 0, 0);
    adv_to(86399);
    chk_a("e86399", 23, 59, 59);
    adv_to(86400);
    chk_a("e86400", 0, 0, 0);
    adv_to(86401);
    chk_a("e86401", 0, 0, 1);

    // mid-operation reset
    rst  = 1'b1;
    rst4 = 1'b1;
    @(posedge clk);
    #1;
    rst  = 1'b0;
    rst4 = 1'b0;
    e    = 0;
    adv_to(125);
    chk_a("e125", 0, 2, 5);
    chk("pre4_e125.s", int'(sec_b), 31);
    #2;
    rst  = 1'b1;
    rst4 = 1'b1;
    #1;
    chk_a("mid_rst", 0, 0, 0);
    chk("mid_rst4.s", int'(sec_b), 0);
    @(negedge clk);
    rst  = 1'b0;
    rst4 = 1'b0;
    e    = 0;
    adv_to(1);
    chk_a("post_rst_e1", 0, 0, 1);
    chk("post_rst4_e1.s", int'(sec_b), 0);
    adv_to(4);
    chk("post_rst4_e4.s", int'(sec_b), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
